// File: rtl/div32_seq.sv
// div32_seq: iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU.
// One 33-bit trial subtract per clock and 32 iterations for the normal path.
// Divide-by-zero and signed overflow finish in a single edge.
// Optional feature macro DIV32_EARLY_OUT_EN: when the divisor magnitude is
// larger than the dividend magnitude, finish in a single edge as well.
module div32_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] X,
   input  logic [XLEN-1:0] Y,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement negation when neg is set, pass-through otherwise.
   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      logic [31:0] r;
      if (neg) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [31:0]       rem_r, rem_s;
   logic [31:0]       quo_r, quo_s;
   logic [31:0]       dvs_r, dvs_s;
   logic              is_rem_r, is_rem_s;
   logic              neg_res_r, neg_res_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic [31:0]       result_r, result_s;

   logic              signed_op_s;
   logic              x_neg_s, y_neg_s;
   logic [31:0]       x_mag_s, y_mag_s;
   logic [32:0]       shifted_s;
   logic [32:0]       trial_s;
   logic [31:0]       rem_iter_s, quo_iter_s;
   logic              last_iter_s;

   // Operand magnitudes and one restoring-division step, evaluated every cycle.
   always_comb begin
      signed_op_s = ~op[0];
      x_neg_s     = signed_op_s & X[31];
      y_neg_s     = signed_op_s & Y[31];
      x_mag_s     = cond_neg(X, x_neg_s);
      y_mag_s     = cond_neg(Y, y_neg_s);
      // Shifted partial remainder can reach 33 bits; the difference always fits 32.
      shifted_s   = {rem_r, quo_r[31]};
      trial_s     = shifted_s - {1'b0, dvs_r};
      if (trial_s[32] == 1'b0) begin
         rem_iter_s = trial_s[31:0];
         quo_iter_s = {quo_r[30:0], 1'b1};
      end else begin
         rem_iter_s = shifted_s[31:0];
         quo_iter_s = {quo_r[30:0], 1'b0};
      end
      last_iter_s = (cnt_r == CNT_W'(XLEN - 1));
   end

   // Next-state, datapath and output decode for the IDLE/CALC/DONE sequencer.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      rem_s     = rem_r;
      quo_s     = quo_r;
      dvs_s     = dvs_r;
      is_rem_s  = is_rem_r;
      neg_res_s = neg_res_r;
      result_s  = result_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               is_rem_s  = op[1];
               // Remainder follows the dividend sign; quotient is negative on sign mismatch.
               neg_res_s = op[1] ? x_neg_s : (x_neg_s ^ y_neg_s);
               if (Y == 32'd0) begin
                  state_s  = DONE;
                  result_s = op[1] ? X : 32'hFFFF_FFFF;
               end else if (signed_op_s && (X == 32'h8000_0000) && (Y == 32'hFFFF_FFFF)) begin
                  state_s  = DONE;
                  result_s = op[1] ? 32'd0 : 32'h8000_0000;
`ifdef DIV32_EARLY_OUT_EN
               end else if (y_mag_s > x_mag_s) begin
                  state_s  = DONE;
                  result_s = op[1] ? X : 32'd0;
`endif
               end else begin
                  state_s = CALC;
                  cnt_s   = {CNT_W{1'b0}};
                  rem_s   = 32'd0;
                  quo_s   = x_mag_s;
                  dvs_s   = y_mag_s;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            rem_s = rem_iter_s;
            quo_s = quo_iter_s;
            cnt_s = cnt_r + CNT_W'(1);
            if (last_iter_s) begin
               state_s  = DONE;
               result_s = is_rem_r ? cond_neg(rem_iter_s, neg_res_r)
                                   : cond_neg(quo_iter_s, neg_res_r);
            end else begin
               state_s = CALC;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s == CALC);
      done_s = (state_s == DONE);
   end

   // State, datapath and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         rem_r     <= 32'd0;
         quo_r     <= 32'd0;
         dvs_r     <= 32'd0;
         is_rem_r  <= 1'b0;
         neg_res_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         result_r  <= 32'd0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         rem_r     <= rem_s;
         quo_r     <= quo_s;
         dvs_r     <= dvs_s;
         is_rem_r  <= is_rem_s;
         neg_res_r <= neg_res_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         result_r  <= result_s;
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed cases plus randomized operations
// compared against an arithmetic reference model of RV32M division.
module tb_div32_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] X;
   logic [31:0] Y;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   div32_seq dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .X      (X),
      .Y      (Y),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RV32M reference result from plain signed/unsigned arithmetic.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int sx;
      int sy;
      sx = x;
      sy = y;
      if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      case (o)
         2'b00:   return sx / sy;
         2'b01:   return x / y;
         2'b10:   return sx % sy;
         default: return x % y;
      endcase
   endfunction

   // Edges from start to done visible.
   function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] ax;
      logic [31:0] ay;
      if (y == 32'd0) return 1;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      ax = (!o[0] && x[31]) ? -x : x;
      ay = (!o[0] && y[31]) ? -y : y;
`ifdef DIV32_EARLY_OUT_EN
      if (ay > ax) return 1;
`endif
      return 33;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one operation and check busy, latency, result, and the one-cycle done pulse.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int lat;
      int exp_lat;
      logic [31:0] exp_res;
      exp_lat = ref_latency(o, x, y);
      exp_res = ref_result(o, x, y);
      op = o; X = x; Y = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      X = $urandom; Y = $urandom;
      check({tag, "_busy_e0"}, 32'(busy), 32'(exp_lat > 1));
      lat = 1;
      while (!done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_result_hold"}, result, exp_res);
   endtask

   initial begin
      int n_done;
      int lat;
      logic [31:0] res;
      logic [1:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;

      reset = 1'b1; start = 1'b0; op = 2'b00; X = 32'd0; Y = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed cases from the test plan.
      run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
      check("ref_divu_100_7", ref_result(2'b01, 32'd100, 32'd7), 32'd14);
      run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
      run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
      run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
      run_op("divu_by0", 2'b01, 32'd5, 32'd0);
      run_op("rem_by0", 2'b10, 32'd5, 32'd0);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_3_10", 2'b01, 32'd3, 32'd10);
      run_op("remu_3_10", 2'b11, 32'd3, 32'd10);
      run_op("rem_m3_10", 2'b10, 32'hFFFF_FFFD, 32'd10);
      run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);

      // Second start while busy is ignored; exactly one done at the normal time.
      op = 2'b01; X = 32'd100; Y = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_done = 0; lat = 0; res = 32'd0;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         if (done) begin
            n_done++;
            if (n_done == 1) begin
               lat = cyc;
               res = result;
            end
         end
         if (cyc == 10) begin
            X = 32'd1000; Y = 32'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      check("busy_ignore_ndone", n_done, 32'd1);
      check("busy_ignore_latency", lat, 32'd33);
      check("busy_ignore_result", res, 32'd14);

      // Start during the DONE cycle is ignored.
      op = 2'b01; X = 32'd5; Y = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      check("done_start_pulse", 32'(done), 32'd1);
      op = 2'b11; X = 32'd9; Y = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      n_done = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (done) n_done++;
         @(posedge clk); #1;
      end
      check("done_start_ignored", n_done, 32'd0);
      check("done_start_result", result, 32'hFFFF_FFFF);

      // Reset mid-operation aborts without a done pulse.
      op = 2'b01; X = 32'hFFFF_FFFF; Y = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", result, 32'd0);
      n_done = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (done || busy) n_done++;
         @(posedge clk); #1;
      end
      check("abort_no_done", n_done, 32'd0);
      run_op("divu_max_3", 2'b01, 32'hFFFF_FFFF, 32'd3);

      // Randomized operations against the reference model.
      for (int i = 0; i < 50; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         case ($urandom_range(0, 5))
            0:       ry = 32'd0;
            1:       ry = $urandom_range(1, 15);
            2: begin rx = $urandom_range(0, 200); ry = $urandom_range(201, 100000); end
            3: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
            4:       ry = -($urandom_range(1, 1000));
            default: ry = $urandom;
         endcase
         run_op("rand", ro, rx, ry);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
Iterative 32-bit restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the inverse-direction companion to the combinational subtract32 datapath, and it reuses one 33-bit subtract per cycle. It sits beside the ALU in the execute stage. The control unit launches it with start and stalls on busy until done.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
X  input  32  dividend (rs1); sampled with start
Y  input  32  divisor (rs2); sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result valid
result  output  32  quotient or remainder, held until the next accepted start

Behaviour:
- Reset: sampled on a clk edge.
  - Sets state=IDLE, busy=0, done=0, result=0, counter=0.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge E0: latch op, X, Y; busy=1 from E0.
  - Signed ops (00, 10): latch |X| and |Y|, plus sign flags.
  - Y==0, or signed overflow (X=0x80000000, Y=0xFFFFFFFF, signed op): go directly to DONE with the special result at E0.
  - Otherwise: go to CALC, counter=0, remainder reg=0, quotient reg=dividend magnitude.
- CALC, one iteration per edge:
  - Shift {rem,quo} left by 1.
  - Trial subtract: rem - divisor_magnitude, 33-bit.
  - Non-negative: keep the difference and set quo[0]=1. Negative: restore and set quo[0]=0.
  - counter increments.
  - On the 32nd iteration edge (E32): apply sign fix, register result, go to DONE.
- Sign fix:
  - Quotient is negated if sign(X) XOR sign(Y) for DIV.
  - Remainder takes the sign of X for REM.
  - Unsigned ops are unmodified.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE unconditionally.
  - start during DONE is ignored; the requester must re-assert it in IDLE.
- Latency, start edge to done visible:
  - Normal: 33 edges (E0 + 32 iterations, done visible after E32).
  - Special cases: 1 edge (done visible after E0).
- start while busy (CALC) is ignored; latched operands are unaffected by input changes.
- Special results, per the RISC-V spec:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give X.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- result changes only on the edge that enters DONE, or on reset.

Optional Feature:
- Macro: DIV32_EARLY_OUT_EN.
- Defined:
  - In IDLE, if divisor magnitude > dividend magnitude (non-special case), skip CALC and go to DONE at E0.
  - Result: quotient 0; remainder X (signed REM keeps X unchanged).
  - Latency 1 edge, identical to the special-case path.
- Undefined: this case takes the full 32-iteration path. Results are identical either way; only latency differs.

Test Plan:
- DIVU X=100, Y=7, start pulse 1 cycle -> busy=1 for 32 cycles; done pulse after E32; result=14. Repeat with REMU -> result=2.
- DIV X=-7 (0xFFFFFFF9), Y=2 -> result=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); REM X=7, Y=-2 -> 1.
- DIVU X=5, Y=0 -> done after E0, result=0xFFFFFFFF; REM X=5, Y=0 -> result=5; DIV X=0x80000000, Y=0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Start DIVU 100/7, then at cycle 10 change X/Y and pulse start again -> second start ignored; result=14 at the normal time; done pulses exactly once.
- Start DIVU 0xFFFFFFFF/3, assert reset at cycle 15 for 1 cycle -> busy=0, done=0, result=0 next cycle; no later done; a fresh start 0xFFFFFFFF/3 -> result=0x55555555.
- With DIV32_EARLY_OUT_EN: DIVU X=3, Y=10 -> done after E0, result=0; REMU -> 3. Without the macro -> same values, done after E32.
